// File: rtl/mult_div_unit_if.sv
// Operand, start and result bundle between the control unit and the HI/LO multiply/divide unit.
// The control unit connects as master; the unit itself connects as slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, A, B,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, A, B,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide producing HI/LO, one bit per clock on a shared datapath.
// Operands are reduced to magnitudes up front; result signs are applied in FINISH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} stateT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic             isMult, zeroDiv, negLo, negHi;
    logic [WIDTH-1:0] opReg, accHi, accLo, hiReg, loReg;
    logic             doneReg, divZeroReg;
    logic             startAny;
    logic [WIDTH:0]   mulSum, divShift, divTrial;
    logic [2*WIDTH-1:0] product, productFix;

    function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign startAny    = bus.start_mult | bus.start_div;
    assign bus.HI       = hiReg;
    assign bus.LO       = loReg;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = doneReg;
    assign bus.div_zero = divZeroReg;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                // Multiply wins arbitration, so only a lone divide can take the zero-divisor shortcut.
                if (startAny)
                    stateNext = (!bus.start_mult && bus.B == '0) ? FINISH : RUN;
            end
            RUN:     if (cnt == '0) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // accHi is the upper product half or the running remainder; accLo holds the multiplier or dividend.
    always_comb begin
        mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opReg} : '0);
        divShift   = {accHi, accLo[WIDTH-1]};
        divTrial   = divShift - {1'b0, opReg};
        product    = {accHi, accLo};
        productFix = negLo ? (~product + 1'b1) : product;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            isMult     <= 1'b0;
            zeroDiv    <= 1'b0;
            negLo      <= 1'b0;
            negHi      <= 1'b0;
            opReg      <= '0;
            accHi      <= '0;
            accLo      <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            state      <= stateNext;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (startAny) begin
                        isMult  <= bus.start_mult;
                        zeroDiv <= !bus.start_mult && bus.B == '0;
                        cnt     <= CNT_W'(WIDTH - 1);
                        accHi   <= '0;
                        negLo   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        if (bus.start_mult) begin
                            opReg <= absVal(bus.A);
                            accLo <= absVal(bus.B);
                            negHi <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        end else begin
                            opReg <= absVal(bus.B);
                            accLo <= absVal(bus.A);
                            negHi <= bus.A[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (isMult) begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end else if (!divTrial[WIDTH]) begin
                        accHi <= divTrial[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b1};
                    end else begin
                        accHi <= divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    doneReg <= 1'b1;
                    if (zeroDiv) begin
                        divZeroReg <= 1'b1;
                    end else if (isMult) begin
                        hiReg <= productFix[2*WIDTH-1:WIDTH];
                        loReg <= productFix[WIDTH-1:0];
                    end else begin
                        hiReg <= applySign(accHi, negHi);
                        loReg <= applySign(accLo, negLo);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operations against a 64-bit arithmetic model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pickOp();
        int v;
        case ($urandom_range(0, 4))
            0: begin v = $urandom_range(0, 40); return 32'(v - 20); end
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic doOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, input string tag);
        longint sa, sb, r;
        logic [63:0] p;
        int k, extra;
        bit busyGap, expZero;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        expZero = !m && (b == 32'h0);
        if (m) begin
            r = sa * sb; p = r;
            refHi = p[63:32]; refLo = p[31:0];
        end else if (!expZero) begin
            r = sa / sb; p = r; refLo = p[31:0];
            r = sa % sb; p = r; refHi = p[31:0];
        end
        @(negedge clk);
        bus.A = a; bus.B = b; bus.start_mult = m; bus.start_div = d;
        @(negedge clk);
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        checkVal({tag, ".busyStart"}, 64'(bus.busy), 64'd1);
        k = 0; busyGap = 1'b0;
        while (!bus.done && k < 100) begin
            if (!bus.busy) busyGap = 1'b1;
            bus.start_div = intrude && (k == 10);
            @(negedge clk);
            k++;
        end
        bus.start_div = 1'b0;
        checkVal({tag, ".latency"}, 64'(k), expZero ? 64'd1 : 64'd33);
        checkVal({tag, ".HI"}, 64'(bus.HI), 64'(refHi));
        checkVal({tag, ".LO"}, 64'(bus.LO), 64'(refLo));
        checkVal({tag, ".divZero"}, 64'(bus.div_zero), 64'(expZero));
        checkVal({tag, ".busyAtDone"}, 64'(bus.busy), 64'd0);
        checkVal({tag, ".busyGap"}, 64'(busyGap), 64'd0);
        @(negedge clk);
        checkVal({tag, ".donePulse"}, 64'(bus.done), 64'd0);
        checkVal({tag, ".divZeroPulse"}, 64'(bus.div_zero), 64'd0);
        if (intrude) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            checkVal({tag, ".noSecondDone"}, 64'(extra), 64'd0);
            checkVal({tag, ".HIhold"}, 64'(bus.HI), 64'(refHi));
            checkVal({tag, ".LOhold"}, 64'(bus.LO), 64'(refLo));
        end
    endtask

    task automatic resetMidRun();
        @(negedge clk);
        bus.A = 32'd123; bus.B = 32'd456; bus.start_mult = 1'b1;
        @(negedge clk);
        bus.start_mult = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        refHi = '0; refLo = '0;
        checkVal("rst.HI", 64'(bus.HI), 64'd0);
        checkVal("rst.LO", 64'(bus.LO), 64'd0);
        checkVal("rst.busy", 64'(bus.busy), 64'd0);
        checkVal("rst.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        bit m, d;
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.A = '0; bus.B = '0;
        reset = 1'b1;
        #12;
        checkVal("init.HI", 64'(bus.HI), 64'd0);
        checkVal("init.LO", 64'(bus.LO), 64'd0);
        checkVal("init.busy", 64'(bus.busy), 64'd0);
        checkVal("init.done", 64'(bus.done), 64'd0);
        checkVal("init.divZero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        doOp(1, 0, 32'd7, 32'hFFFF_FFFD, 0, "mul7xm3");
        doOp(1, 0, 32'h8000_0000, 32'h8000_0000, 0, "mulMinMin");
        doOp(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulM1M1");
        doOp(0, 1, 32'hFFFF_FFF9, 32'd2, 0, "divM7by2");
        doOp(0, 1, 32'd100, 32'd7, 0, "div100by7");
        doOp(1, 0, 32'd1234, 32'hFFFF_FF00, 0, "preload");
        doOp(0, 1, 32'd5, 32'd0, 0, "divByZero");
        doOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divOverflow");
        doOp(1, 1, 32'd6, 32'd3, 0, "bothStarts");
        doOp(1, 0, 32'd11, 32'd13, 1, "intrudeDiv");
        resetMidRun();
        doOp(1, 0, 32'd2, 32'd3, 0, "afterReset");

        for (int i = 0; i < 24; i++) begin
            a = pickOp();
            b = pickOp();
            case ($urandom_range(0, 2))
                0: begin m = 1'b1; d = 1'b0; end
                1: begin m = 1'b0; d = 1'b1; end
                default: begin m = 1'b1; d = 1'b1; end
            endcase
            doOp(m, d, a, b, 0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
